status_frame_tx: RTL and testbench
==================================

Name: status_frame_tx

Overview:
Transmit-side counterpart of the command-frame receiver in the switch core. Snapshots switch state and CPU error counters, then builds a fixed 8-byte status frame. Pushes the frame byte-by-byte into a UART TX FIFO through its tdr/tf_push interface. After each frame it enforces a minimum idle gap, so the far-end receiver's idle-timeout framing (GAP_T byte times) delimits frames correctly.

Parameters:
- FIFO_DEPTH, 16, depth of the downstream UART TX FIFO.
- GAP_CYCLES, `GAP_T*160*DL, idle clk cycles guaranteed between frames; must match the receiver's MAX_IDLE_T.
- HDR0, 8'hEB, first sync byte.
- HDR1, 8'h90, second sync byte.
- PERIOD_CYCLES, 32'd10_000_000, auto-send period; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- send_req  in  1  one-cycle request to send a status frame.
- switch_i  in  1  current CPU selection (0 = A, 1 = B).
- error_i  in  1  command error flag.
- a_err_num  in  8  CPU A error count.
- b_err_num  in  8  CPU B error count.
- tf_count  in  `UART_FIFO_COUNTER_W  occupancy of the UART TX FIFO.
- tdr  out  8  byte to push.
- tf_push  out  1  one-cycle push strobe; tdr is valid while it is high.
- busy  out  1  high from LOAD through the end of GAP.
- frame_done  out  1  one-cycle pulse when the last byte is pushed.
- seq  out  8  sequence number of the most recently started frame.

Behaviour:
- Reset values: tdr=0, tf_push=0, busy=0, frame_done=0, seq=0, pending=0, state=IDLE. Reset has priority in every state.
- Frame layout, in order: HDR0, HDR1, LEN=8'h04, STAT={5'b0,error,switch,1'b1}, AERR, BERR, SEQ, CSUM.
  - CSUM = 8-bit modulo sum of LEN..SEQ; carries are discarded.
- FSM states and transitions:
  - IDLE: on send_req or pending, go to LOAD the next cycle.
  - LOAD (1 cycle): snapshot switch_i, error_i, a_err_num, b_err_num; seq <= seq+1, wrapping 255->0; byte index <= 0; busy=1.
  - SEND: push one byte when tf_count < FIFO_DEPTH-2 and tf_push was low the previous cycle. Pushes are therefore at most every other cycle, which absorbs the one-cycle tf_count update latency. Index 7 push asserts frame_done in the same cycle, then go to DRAIN.
  - DRAIN: wait for tf_count==0.
  - GAP: count GAP_CYCLES, then go to IDLE (or straight to LOAD if pending, with busy held high).
- Timing:
  - Latency from send_req to the first tf_push is 2 cycles when the FIFO has room.
  - Best-case frame push window is 15 cycles.
  - The GAP count starts after the FIFO is empty, so the final byte's shift time lies inside the gap (conservative).
- Payload is taken from the LOAD snapshot only; input changes during SEND do not affect the frame in flight.
- send_req while busy sets the one-deep pending flag. Further requests while pending is set are dropped. pending clears on entry to LOAD.
- send_req in the same cycle that GAP completes is serviced; no request is lost.
- FIFO full (tf_count >= FIFO_DEPTH-2): stall in SEND with tf_push=0; byte index and checksum hold.
- Reset mid-frame: the FSM returns to IDLE and tf_push drops in the same cycle. Bytes already in the FIFO are not recalled, and seq resets to 0.

Optional Feature:
- STATUS_TX_PERIODIC_EN defined: a 32-bit free-running timer raises an internal request every PERIOD_CYCLES. It is ORed with send_req and subject to the same pending rules. The timer resets with rst and restarts at 0 on wrap.
- STATUS_TX_PERIODIC_EN undefined: there is no timer logic, and frames are sent only on send_req.

Decomposition:
- Shared include status_tx_defines.v holds:
  - HDR0/HDR1
  - LEN value 4
  - frame byte count 8
  - FSM state encodings (IDLE, LOAD, SEND, DRAIN, GAP)
  - STAT bit positions
- Sub-module gap_timer: loadable down-counter with a done pulse, parameterised by width.
  - Reused for the GAP state.
  - Reused for the periodic timer when STATUS_TX_PERIODIC_EN is defined.

Test Plan:
1. Reset, then send_req with switch_i=1, error_i=0, a_err=8'h03, b_err=8'h00, tf_count=0 -> pushed bytes are EB 90 04 03 03 00 01 0B; frame_done on the 8th push; seq=1.
2. Hold tf_count=14 after the 3rd push for 50 cycles -> no tf_push during the hold; the remaining 5 bytes follow after release, identical to the unstalled frame.
3. Two send_req pulses 3 cycles apart, then a third pulse during SEND -> exactly 2 frames (seq 1, 2); the second LOAD occurs only after GAP_CYCLES of empty-FIFO idle; the third request is dropped.
4. Change a_err_num from 8'h03 to 8'hFF during SEND -> the frame still carries 03 and checksum 0B.
5. Assert rst after the 4th push -> tf_push=0 and busy=0 on the next edge; seq=0; a new send_req produces a full frame with seq=1.
6. With STATUS_TX_PERIODIC_EN defined and PERIOD_CYCLES=1000 -> frames start at a 1000-cycle cadence with no send_req; seq increments 1, 2, 3.

Source files
------------

// File: rtl/status_frame_tx_pkg.sv
// Shared constants, FSM encoding and STAT byte layout for the status frame transmitter.
// Build-time macros: UART_FIFO_COUNTER_W (tf_count width), GAP_T and DL (inter-frame gap sizing).
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif
`ifndef GAP_T
`define GAP_T 3
`endif
`ifndef DL
`define DL 1
`endif

package status_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    localparam logic [7:0] HDR0_DEF    = 8'hEB;
    localparam logic [7:0] HDR1_DEF    = 8'h90;
    localparam logic [7:0] LEN_VAL     = 8'h04;
    localparam int         FRAME_BYTES = 8;

    localparam int STAT_ONE_BIT    = 0;
    localparam int STAT_SWITCH_BIT = 1;
    localparam int STAT_ERROR_BIT  = 2;

    function automatic logic [7:0] stat_byte(input logic sw, input logic err);
        logic [7:0] s;
        s                  = 8'h00;
        s[STAT_ONE_BIT]    = 1'b1;
        s[STAT_SWITCH_BIT] = sw;
        s[STAT_ERROR_BIT]  = err;
        return s;
    endfunction

endpackage

// File: rtl/status_frame_tx_gap_timer.sv
// Loadable down-counter with a registered one-cycle done pulse when it reaches zero.
module gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_r;
    logic         done_r;

    // Count down from the loaded value; done fires on the 1 -> 0 step.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            done_r  <= 1'b0;
        end else if (load) begin
            count_r <= load_val;
            done_r  <= 1'b0;
        end else if (en && (count_r != '0)) begin
            count_r <= count_r - W'(1);
            done_r  <= (count_r == W'(1));
        end else begin
            done_r  <= 1'b0;
        end
    end

    assign done = done_r;

endmodule

// File: rtl/status_frame_tx.sv
// Builds and pushes the 8-byte status frame into the UART TX FIFO, then holds an idle gap.
// Optional build macro STATUS_TX_PERIODIC_EN adds a free-running auto-send timer.
import status_frame_tx_pkg::*;

module status_frame_tx #(
    parameter int          FIFO_DEPTH    = 16,
    parameter int          GAP_CYCLES    = `GAP_T * 160 * `DL,
    parameter logic [7:0]  HDR0          = HDR0_DEF,
    parameter logic [7:0]  HDR1          = HDR1_DEF,
    parameter logic [31:0] PERIOD_CYCLES = 32'd10_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            send_req,
    input  logic                            switch_i,
    input  logic                            error_i,
    input  logic [7:0]                      a_err_num,
    input  logic [7:0]                      b_err_num,
    input  logic [`UART_FIFO_COUNTER_W-1:0] tf_count,
    output logic [7:0]                      tdr,
    output logic                            tf_push,
    output logic                            busy,
    output logic                            frame_done,
    output logic [7:0]                      seq
);

    localparam int              CW       = `UART_FIFO_COUNTER_W;
    localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0]   FULL_LVL = CW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0]   ZERO_CNT = CW'(0);
    localparam logic [2:0]      LAST_IDX = 3'(FRAME_BYTES - 1);

    tx_state_e  state_r;
    logic       pending_r;
    logic [2:0] idx_r;
    logic [7:0] csum_r;
    logic       snap_sw_r;
    logic       snap_err_r;
    logic [7:0] snap_a_r;
    logic [7:0] snap_b_r;
    logic [7:0] tdr_r;
    logic [7:0] seq_r;
    logic       tf_push_r;
    logic       busy_r;
    logic       frame_done_r;

    logic       req_s;
    logic       can_push_s;
    logic       gap_load_s;
    logic       gap_done_s;
    logic [7:0] byte_s;

`ifdef STATUS_TX_PERIODIC_EN
    logic per_start_r;
    logic per_done_s;

    // Kick the period timer once after reset; afterwards it reloads on each done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_start_r <= 1'b1;
        end else begin
            per_start_r <= 1'b0;
        end
    end

    gap_timer #(.W(32)) u_period (
        .clk      (clk),
        .rst      (rst),
        .load     (per_start_r | per_done_s),
        .en       (1'b1),
        .load_val (PERIOD_CYCLES - 32'd1),
        .done     (per_done_s)
    );

    assign req_s = send_req | per_done_s;
`else
    assign req_s = send_req;
`endif

    // Waiting one cycle after each push lets tf_count catch up before the next decision.
    assign can_push_s = (tf_count < FULL_LVL) && !tf_push_r;
    assign gap_load_s = (state_r == ST_DRAIN) && (tf_count == ZERO_CNT);

    gap_timer #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load_s),
        .en       (state_r == ST_GAP),
        .load_val (GAP_W'(GAP_CYCLES)),
        .done     (gap_done_s)
    );

    // Frame byte selected by the current index, built only from the LOAD snapshot.
    always_comb begin
        byte_s = 8'h00;
        case (idx_r)
            3'd0:    byte_s = HDR0;
            3'd1:    byte_s = HDR1;
            3'd2:    byte_s = LEN_VAL;
            3'd3:    byte_s = stat_byte(snap_sw_r, snap_err_r);
            3'd4:    byte_s = snap_a_r;
            3'd5:    byte_s = snap_b_r;
            3'd6:    byte_s = seq_r;
            3'd7:    byte_s = csum_r;
            default: byte_s = 8'h00;
        endcase
    end

    // Frame sequencer: request/pending handling, byte pushes, drain and inter-frame gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pending_r    <= 1'b0;
            idx_r        <= 3'd0;
            csum_r       <= 8'h00;
            snap_sw_r    <= 1'b0;
            snap_err_r   <= 1'b0;
            snap_a_r     <= 8'h00;
            snap_b_r     <= 8'h00;
            tdr_r        <= 8'h00;
            seq_r        <= 8'h00;
            tf_push_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            tf_push_r    <= 1'b0;
            frame_done_r <= 1'b0;
            if (req_s && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req_s || pending_r) begin
                        state_r   <= ST_LOAD;
                        busy_r    <= 1'b1;
                        pending_r <= 1'b0;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    snap_sw_r  <= switch_i;
                    snap_err_r <= error_i;
                    snap_a_r   <= a_err_num;
                    snap_b_r   <= b_err_num;
                    seq_r      <= seq_r + 8'd1;
                    csum_r     <= 8'h00;
                    state_r    <= ST_SEND;
                    // The first header byte needs no snapshot, so it can leave straight away.
                    if (can_push_s) begin
                        tdr_r     <= HDR0;
                        tf_push_r <= 1'b1;
                        idx_r     <= 3'd1;
                    end else begin
                        idx_r     <= 3'd0;
                    end
                end
                ST_SEND: begin
                    if (can_push_s) begin
                        tdr_r     <= byte_s;
                        tf_push_r <= 1'b1;
                        if ((idx_r >= 3'd2) && (idx_r <= 3'd6)) begin
                            csum_r <= csum_r + byte_s;
                        end
                        if (idx_r == LAST_IDX) begin
                            frame_done_r <= 1'b1;
                            state_r      <= ST_DRAIN;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tf_count == ZERO_CNT) begin
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done_s) begin
                        if (req_s || pending_r) begin
                            state_r   <= ST_LOAD;
                            pending_r <= 1'b0;
                        end else begin
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign tdr        = tdr_r;
    assign tf_push    = tf_push_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign seq        = seq_r;

endmodule

// File: tb/tb_status_frame_tx.sv
// Randomised bench for status_frame_tx: frame model, FIFO occupancy model and directed scenarios.
module tb_status_frame_tx;

    localparam int GAP = 40;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_req;
    logic       switch_i;
    logic       error_i;
    logic [7:0] a_err_num;
    logic [7:0] b_err_num;
    logic [4:0] tf_count;
    wire  [7:0] tdr;
    wire        tf_push;
    wire        busy;
    wire        frame_done;
    wire  [7:0] seq;

    status_frame_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .send_req(send_req), .switch_i(switch_i), .error_i(error_i),
        .a_err_num(a_err_num), .b_err_num(b_err_num), .tf_count(tf_count),
        .tdr(tdr), .tf_push(tf_push), .busy(busy), .frame_done(frame_done), .seq(seq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fifo_cnt = 0;
    bit inc_pipe = 1'b0;
    int drain_pct = 100;
    int hold_until = -1;
    int pos = 0;
    int model_seq = 0;
    int frames_done = 0;
    int last_done_cyc = -1;
    int z_cyc = -1;
    int first_push_cyc = -1;
    bit prev_push = 1'b0;
    bit rand_payload = 1'b0;
    logic [4:0] tfc_seen;
    logic [7:0] exp_frame [8];
    logic [7:0] push_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected frame from the payload the DUT must have snapshotted.
    task automatic build_frame(input logic sw, input logic err, input logic [7:0] a,
                               input logic [7:0] b, input int s);
        int stat;
        stat = 1 + (sw ? 2 : 0) + (err ? 4 : 0);
        exp_frame[0] = 8'hEB;
        exp_frame[1] = 8'h90;
        exp_frame[2] = 8'h04;
        exp_frame[3] = 8'(stat);
        exp_frame[4] = a;
        exp_frame[5] = b;
        exp_frame[6] = 8'(s);
        exp_frame[7] = 8'((4 + stat + int'(a) + int'(b) + s) % 256);
    endtask

    // One clock: compare outputs against the model, then advance the FIFO model.
    task automatic step();
        @(negedge clk);
        cyc++;
        tfc_seen = tf_count;
        if (rst) begin
            chk("rst_tf_push", {31'd0, tf_push}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
            chk("rst_seq", {24'd0, seq}, 32'd0);
            chk("rst_tdr", {24'd0, tdr}, 32'd0);
            pos = 0;
            model_seq = 0;
            last_done_cyc = -1;
            z_cyc = -1;
        end else begin
            if (last_done_cyc >= 0 && z_cyc < 0 && cyc > last_done_cyc && tfc_seen == 5'd0)
                z_cyc = cyc;
            if (tf_push) begin
                chk("push_spacing", {31'd0, prev_push}, 32'd0);
                chk("push_room", {31'd0, (tfc_seen < 5'(DEPTH - 2))}, 32'd1);
                if (pos == 0) begin
                    model_seq = (model_seq + 1) % 256;
                    build_frame(switch_i, error_i, a_err_num, b_err_num, model_seq);
                    first_push_cyc = cyc;
                    if (z_cyc >= 0)
                        chk("gap_len_ok", {31'd0, ((cyc - z_cyc) >= GAP + 1)}, 32'd1);
                    last_done_cyc = -1;
                    z_cyc = -1;
                    if (rand_payload) begin
                        switch_i = 1'($urandom);
                        error_i = 1'($urandom);
                        a_err_num = 8'($urandom);
                        b_err_num = 8'($urandom);
                    end
                end
                chk("tdr", {24'd0, tdr}, {24'd0, exp_frame[pos]});
                chk("frame_done", {31'd0, frame_done}, {31'd0, (pos == 7)});
                chk("seq", {24'd0, seq}, 32'(model_seq));
                chk("busy_in_frame", {31'd0, busy}, 32'd1);
                push_log.push_back(tdr);
                if (pos == 7) begin
                    pos = 0;
                    frames_done++;
                    last_done_cyc = cyc;
                end else begin
                    pos++;
                end
            end else begin
                chk("frame_done_no_push", {31'd0, frame_done}, 32'd0);
            end
        end
        prev_push = tf_push;
        if (fifo_cnt > 0 && $urandom_range(99) < drain_pct) fifo_cnt--;
        fifo_cnt += int'(inc_pipe);
        inc_pipe = tf_push;
        if (fifo_cnt > DEPTH) chk("fifo_overflow", 32'(fifo_cnt), 32'(DEPTH));
        tf_count = (cyc < hold_until) ? 5'd14 : 5'(fifo_cnt);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        step();
        send_req = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target;
        int k;
        target = frames_done + n;
        k = 0;
        while (frames_done < target && k < budget) begin
            step();
            k++;
        end
        if (frames_done < target) begin
            total++;
            bad++;
            $display("FAIL wait_frames: timeout after %0d cycles, frames=%0d need=%0d", budget, frames_done, target);
        end
    endtask

    task automatic wait_pos(input int p, input int budget);
        int k;
        k = 0;
        while (pos < p && k < budget) begin
            step();
            k++;
        end
        if (pos < p) begin
            total++;
            bad++;
            $display("FAIL wait_pos: timeout, pos=%0d need=%0d", pos, p);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still high after %0d cycles", budget);
        end
    endtask

    // Hand-computed frame for STAT=03, AERR=03, BERR=00 with the given SEQ and CSUM.
    task automatic check_log(input string name, input logic [7:0] s, input logic [7:0] cs);
        logic [7:0] ref_b [8];
        ref_b = '{8'hEB, 8'h90, 8'h04, 8'h03, 8'h03, 8'h00, s, cs};
        chk({name, "_len"}, 32'(push_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < push_log.size()) chk(name, {24'd0, push_log[i]}, {24'd0, ref_b[i]});
        end
    endtask

    initial begin
        int req_cyc;
        int f0;
        rst = 1'b1;
        send_req = 1'b0;
        switch_i = 1'b1;
        error_i = 1'b0;
        a_err_num = 8'h03;
        b_err_num = 8'h00;
        tf_count = 5'd0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Basic frame, latency and push window.
        push_log.delete();
        req_cyc = cyc;
        pulse_req();
        wait_frames(1, 100);
        check_log("t1_byte", 8'h01, 8'h0B);
        chk("t1_latency", 32'(first_push_cyc - req_cyc), 32'd2);
        chk("t1_window", 32'(last_done_cyc - first_push_cyc), 32'd14);
        chk("t1_seq", {24'd0, seq}, 32'd1);
        wait_idle(600);

        // FIFO held near full after the third push.
        push_log.delete();
        pulse_req();
        wait_pos(3, 100);
        hold_until = cyc + 51;
        wait_frames(1, 200);
        check_log("t2_byte", 8'h02, 8'h0C);
        chk("t2_stalled", {31'd0, ((last_done_cyc - first_push_cyc) >= 50)}, 32'd1);
        wait_idle(600);

        // Pending request serviced after the gap; third request dropped.
        f0 = frames_done;
        pulse_req();
        repeat (2) step();
        pulse_req();
        wait_pos(4, 100);
        pulse_req();
        wait_frames(2, 800);
        wait_idle(600);
        repeat (GAP + 60) step();
        chk("t3_frames", 32'(frames_done - f0), 32'd2);
        chk("t3_seq", {24'd0, seq}, 32'd4);

        // Reset after the fourth push.
        pulse_req();
        wait_pos(4, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        repeat (10) step();

        // Payload change during SEND must not reach the frame in flight.
        push_log.delete();
        pulse_req();
        wait_pos(1, 100);
        a_err_num = 8'hFF;
        wait_frames(1, 100);
        check_log("t4_byte", 8'h01, 8'h0B);
        wait_idle(600);

        // Randomised payloads, idle spacing and FIFO drain rate.
        rand_payload = 1'b1;
        drain_pct = 30;
        f0 = frames_done;
        for (int n = 0; n < 12; n++) begin
            wait_idle(800);
            repeat ($urandom_range(15)) step();
            switch_i = 1'($urandom);
            error_i = 1'($urandom);
            a_err_num = 8'($urandom);
            b_err_num = 8'($urandom);
            pulse_req();
            wait_frames(1, 400);
        end
        wait_idle(800);
        chk("rand_frames", 32'(frames_done - f0), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
